rtport_tx: RTL
==============

# rtport_tx

Buffered transmitter for the router's `RTPort` link: the sending end of the req/ack/data handshake whose receive side is the `RTPort` `Input` modport. The router core pushes flits through a valid/ready interface into a small FIFO. The block serialises them onto one outgoing link using a four-phase, return-to-zero handshake. One instance sits on each output port of a router of any `router_type`, from corner up to `MIDDLE`.

## Interface
Parameters:
- `WIDTH`, 512: flit width; matches the `RTPort` `WIDTH`.
- `DEPTH`, 4: FIFO entries; a power of 2, at least 2.
- `CNT_W`, 16: width of the sent-flit counter.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: the core offers a flit.
- `in_ready`, output, 1: the FIFO can accept a flit; equals `!full`.
- `in_data`, input, `WIDTH`: flit from the core.
- `tx_req`, output, 1: `RTPort` `Output` modport `req`.
- `tx_data`, output, `WIDTH`: `RTPort` `Output` modport `data`.
- `tx_ack`, input, 1: `RTPort` `Output` modport `ack`.
- `busy`, output, 1: high when the FSM is not IDLE or the FIFO is non-empty.
- `level`, output, `$clog2(DEPTH+1)`: FIFO occupancy.
- `sent_count`, output, `CNT_W`: number of flits completed.
- `proto_err`, output, 1: sticky protocol-violation flag.

## Operation
- The FIFO pushes on `in_valid && in_ready`. There is no bypass: a push into a full FIFO is impossible because `in_ready` is 0. Push and pop in the same cycle are both honoured and leave `level` unchanged.
- The FSM has three states: IDLE, REQ and RELEASE.
- IDLE:
  - Move to REQ when the FIFO is non-empty and `tx_ack`=0.
  - On that transition, load the `tx_data` register from the FIFO head and set `tx_req`=1.
- REQ:
  - Hold `tx_req`=1 and keep `tx_data` stable.
  - When `tx_ack`=1 is sampled: pop the FIFO, set `tx_req`=0, increment `sent_count`, and move to RELEASE.
- RELEASE:
  - Hold `tx_req`=0 and keep `tx_data` stable.
  - When `tx_ack`=0 is sampled and the FIFO is non-empty after the pop, load the new head, set `tx_req`=1 and move to REQ.
  - When `tx_ack`=0 is sampled and the FIFO is empty, move to IDLE.
- `tx_data` changes only on an IDLE→REQ or RELEASE→REQ transition. Between transfers it holds the last flit sent.
- `sent_count` wraps modulo 2^`CNT_W`.
- `proto_err` is set when `tx_ack`=1 is sampled in IDLE. It stays set until `rst`. While `tx_ack` stays high in IDLE, no new request is raised.
- `tx_req` comes straight from a flop, with no combinational path from `tx_ack` or `in_valid`.

## Timing
- Reset values:
  - `tx_req`=0
  - `tx_data`=0
  - `in_ready`=1
  - `busy`=0
  - `level`=0
  - `sent_count`=0
  - `proto_err`=0
  - FSM state IDLE, FIFO empty
- Reset takes effect immediately and asynchronously, mid-transfer included. `tx_req` drops at once and FIFO contents are discarded.
- Latency from accept to request: a flit accepted at edge k into an empty FIFO with the FSM in IDLE gives `tx_req`=1 after edge k+1.
- Latency from ack to release: `tx_ack`=1 sampled at edge n gives `tx_req`=0 and the pop after edge n.
- Throughput: with a receiver that registers `ack` one cycle after seeing `req`, a back-to-back flit costs 4 cycles (req↑, ack↑, req↓, ack↓, then req↑ on the next flit).
- `in_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop from a full FIFO.

## Test plan
- Single flit:
  - Stimulus: after reset, push `in_data`=0xA5 with a registered-ack receiver model.
  - Required: `tx_req` rises 2 cycles after the accept with `tx_data`=0xA5; 4-phase completes; `sent_count`=1; `busy`=0 and FSM IDLE afterward.
- Burst of DEPTH+2:
  - Stimulus: push flits 1..6 back-to-back (DEPTH=4) while the receiver is stalled with `tx_ack`=0.
  - Required: `in_ready`=0 once `level`=4; after the receiver is released, flits appear in order 1..6 at 4 cycles each; `sent_count`=6.
- Ack-low stall:
  - Stimulus: hold `tx_ack`=1 for 10 cycles after the pop.
  - Required: `tx_req` stays 0 and `tx_data` stays unchanged; the next req rises 1 cycle after `tx_ack` falls.
- Protocol error:
  - Stimulus: drive `tx_ack`=1 in IDLE with the FIFO empty, then push one flit.
  - Required: `proto_err`=1 and remains set; `tx_req` stays 0 until `tx_ack`=0, then the flit transfers normally.
- Reset mid-transfer:
  - Stimulus: assert `rst` while in REQ with `level`=3.
  - Required: `tx_req`=0 immediately; `level`=0 and `sent_count`=0; no stale flit is sent after release.
- Counter wrap:
  - Stimulus: set `CNT_W`=4 and send 17 flits.
  - Required: `sent_count`=1.

Source files
------------

// File: rtl/rtport_tx.sv
// Buffered transmitter for the RTPort link: a small flit FIFO drained through a
// four-phase return-to-zero req/ack handshake, with a sent-flit counter and sticky protocol flag.
module rtport_tx #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       tx_req,
  output logic [WIDTH-1:0]           tx_data,
  input  logic                       tx_ack,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           sent_count,
  output logic                       proto_err
);

  // state   | meaning
  // IDLE    | no flit on the link; waiting for FIFO data with ack low
  // REQ     | req high, tx_data valid; waiting for ack high
  // RELEASE | req low after ack; waiting for ack low before the next flit
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign push     = in_valid && !full;
  assign pop      = (state == REQ) && tx_ack;
  assign in_ready = !full;
  assign busy     = (state != IDLE) || !empty;

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx_req     <= 1'b0;
      tx_data    <= '0;
      sent_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_ack) begin
            proto_err <= 1'b1;
          end else if (!empty) begin
            tx_data <= mem[rd_ptr];
            tx_req  <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (tx_ack) begin
            tx_req     <= 1'b0;
            sent_count <= sent_count + CNT_W'(1);
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          // The pop already advanced rd_ptr, so the head here is the next flit.
          if (!tx_ack) begin
            if (!empty) begin
              tx_data <= mem[rd_ptr];
              tx_req  <= 1'b1;
              state   <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          tx_req <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
